acc_datapath_p: RTL and testbench
=================================

# acc_datapath_p

Parametrised accumulator datapath for the BIP-style processor. It generalises the fixed 16-bit load/add/sub accumulator path: configurable data and immediate widths, an 8-operation ALU, status flags, and a multi-cycle shift-add multiplier with a busy/done handshake. It sits between the control unit, which drives the SelA/SelB/WrAcc/Op strobes, and data memory, which supplies `data_from_memory`. It exposes the accumulator and flags back to control.

## Interface

Parameters:

- `DATA_W`, 16, accumulator/ALU width (≥4)
- `IMM_W`, 11, immediate operand width (≤ `DATA_W`)
- `SH_W`, `$clog2(DATA_W)`, shift-amount bits taken from operand B

Ports:

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `imm_operand`  in  `IMM_W`  immediate from instruction, sign-extended to `DATA_W`
- `data_from_memory`  in  `DATA_W`  memory read data
- `SelA`  in  2  accumulator source select: 0 memory, 1 immediate, 2 ALU result, 3 hold
- `SelB`  in  1  ALU operand B: 0 memory, 1 immediate
- `WrAcc`  in  1  accumulator write enable
- `Op`  in  3  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA, 7 MUL
- `out_accumulator`  out  `DATA_W`  accumulator register
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  out  1 each  zero, negative, carry, overflow
- `busy`  out  1  multiplier in progress
- `done`  out  1  one-cycle pulse when a MUL result is written

## Operation

- Operand A is always `out_accumulator`. Operand B is selected by `SelB`. The immediate is sign-extended.
- An accumulator write happens on an edge with `WrAcc`=1, `busy`=0 and `SelA`≠3. Sources:
  - SelA 0: memory
  - SelA 1: immediate
  - SelA 2: ALU result (Op 0–6)
- SLL/SRA shift amount is `B[SH_W-1:0]`. SRA is arithmetic.
- Flags update only on accumulator writes.
  - Z and N always reflect the new value.
  - ADD: C = unsigned carry-out; V = signed overflow.
  - SUB: C = 1 when no borrow (A ≥ B unsigned); V = signed overflow.
  - Logic ops and shifts: C=0, V=0.
  - Loads (SelA 0/1): C=0, V=0.
- MUL (SelA 2, Op 7, WrAcc 1, idle) launches the multiplier.
  - Operands A and B are latched at launch.
  - The accumulator and flags hold their old values until completion.
  - Result is the low `DATA_W` bits of the unsigned product.
  - C = 1 if the upper product half is non-zero; V = 0.
- Multiplier FSM:
  - IDLE → RUN on launch.
  - RUN iterates `DATA_W` times, one partial product per cycle.
  - RUN → IDLE after the last iteration, writing the accumulator and flags.
- While `busy`=1, all `WrAcc` requests are ignored: no load, no launch. Control must wait for `done`.

## Timing

- Reset (asynchronous, `reset`=0): `out_accumulator`=0, all flags 0, `busy`=0, `done`=0, FSM=IDLE, iteration counter=0.
- Single-cycle ops: the result appears on `out_accumulator` and the flags after the write edge. Latency is 1 cycle.
- MUL:
  - Launch edge E0: `busy` rises after E0.
  - Iterations occur on edges E1…E`DATA_W`.
  - At E`DATA_W`: accumulator and flags are written, `busy` falls, and `done` is high for exactly one cycle.
  - Total latency is `DATA_W` cycles; a back-to-back op can be accepted on the edge after E`DATA_W`.
- A launch attempted on the same edge that `busy` falls is ignored; `busy` is sampled as 1.
- Reset asserted mid-MUL aborts immediately. No partial result is written.
- Multiplier iteration counter width is `$clog2(DATA_W+1)` bits; it does not wrap during normal operation.

## Structure

- Shared package `bip_pkg`: opcode localparams (`OP_ADD`…`OP_MUL`), SelA encodings (`SELA_MEM`, `SELA_IMM`, `SELA_ALU`, `SELA_HOLD`), SelB encodings.
- Sub-module `seq_multiplier`:
  - Parameterised by `DATA_W`.
  - Ports: `clk`, `reset`, `start`, `a`, `b`, `busy`, `done`, `product[2*DATA_W-1:0]`.
  - Contains the FSM and counter.
- The top level contains the combinational ALU, operand muxes, accumulator and flag registers.

## Test plan

1. Reset → acc=0x0000, flags 0; load imm 5 (SelA 1) → acc=5; ADD imm 4 → acc=9, Z=0, C=0.
2. Load imm 11'h7FF → acc=0xFFFF, N=1; ADD imm 1 → acc=0x0000, Z=1, C=1, V=0.
3. Load memory 0x7FFF; ADD imm 1 → acc=0x8000, V=1, N=1. SUB memory 0x8001 from 0x8000 → acc=0xFFFF, C=0.
4. acc=9, MUL imm 7 → `busy` high 16 cycles, acc still 9 during the run; then acc=63, `done` pulses 1 cycle, C=0. Load attempt during `busy` is ignored.
5. acc=0x0100, MUL memory 0x0100 → acc=0x0000, Z=1, C=1. SRA imm 4 on acc=0x8000 → 0xF800. SLL imm 1 on 0x4001 → 0x8002.
6. Reset asserted at iteration 5 of a MUL → acc=0, `busy`=0, no `done`; a subsequent MUL 3×3 → 9.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared encodings for the BIP accumulator datapath: ALU opcodes, operand
// selects, the flag bundle and the multiplier FSM states.
package bip_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] SELA_MEM  = 2'd0;
  localparam logic [1:0] SELA_IMM  = 2'd1;
  localparam logic [1:0] SELA_ALU  = 2'd2;
  localparam logic [1:0] SELA_HOLD = 2'd3;

  localparam logic SELB_MEM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    MUL_IDLE,
    MUL_RUN
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier: one partial product per cycle, DATA_W cycles.
// `product` already includes the current partial sum, so `done` marks the edge that completes it.
module seq_multiplier
  import bip_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  mul_state_t                state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [2*DATA_W-1:0]       a_q;
  logic [DATA_W-1:0]         b_q;
  logic [2*DATA_W-1:0]       prod_q;
  logic                      last_iter;

  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));
  assign busy      = (state_q == MUL_RUN);
  assign done      = busy && last_iter;
  // After completion b_q has shifted out to zero, so product holds the final value.
  assign product   = prod_q + (b_q[0] ? a_q : '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        MUL_IDLE: begin
          if (start) begin
            a_q     <= {{DATA_W{1'b0}}, a};
            b_q     <= b;
            prod_q  <= '0;
            cnt_q   <= '0;
            state_q <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          prod_q <= product;
          a_q    <= a_q << 1;
          b_q    <= b_q >> 1;
          if (last_iter) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/acc_datapath_p.sv
// Parametrised accumulator datapath: operand muxes, 8-op ALU, accumulator and
// flag registers, with MUL delegated to the sequential multiplier.
module acc_datapath_p
  import bip_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 11,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IMM_W-1:0]    imm_operand,
  input  logic [DATA_W-1:0]   data_from_memory,
  input  logic [1:0]          SelA,
  input  logic                SelB,
  input  logic                WrAcc,
  input  logic [2:0]          Op,
  output logic [DATA_W-1:0]   out_accumulator,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_c,
  output logic                flag_v,
  output logic                busy,
  output logic                done
);

  logic [DATA_W-1:0]   acc_q;
  flags_t              flags_q;
  logic                done_q;

  logic [DATA_W-1:0]   imm_sext;
  logic [DATA_W-1:0]   opb;
  logic [SH_W-1:0]     shamt;
  logic [DATA_W:0]     sum_ext;
  logic [DATA_W:0]     diff_ext;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_v;

  logic                mul_start;
  logic                mul_busy;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;

  logic                wr_en;
  logic [DATA_W-1:0]   wr_val;
  logic                wr_c;
  logic                wr_v;

  if (IMM_W < DATA_W) begin : g_sext
    assign imm_sext = {{(DATA_W - IMM_W){imm_operand[IMM_W-1]}}, imm_operand};
  end else begin : g_nosext
    assign imm_sext = imm_operand[DATA_W-1:0];
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    opb = data_from_memory;
    unique case (SelB)
      SELB_MEM: opb = data_from_memory;
      SELB_IMM: opb = imm_sext;
    endcase
  end

  assign shamt    = opb[SH_W-1:0];
  assign sum_ext  = {1'b0, acc_q} + {1'b0, opb};
  // Subtraction as A + ~B + 1: the carry-out is 1 exactly when no borrow occurs.
  assign diff_ext = {1'b0, acc_q} + {1'b0, ~opb} + (DATA_W + 1)'(1);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (Op)
      OP_ADD: begin
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = (acc_q[DATA_W-1] == opb[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != acc_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[DATA_W-1:0];
        alu_c   = diff_ext[DATA_W];
        alu_v   = (acc_q[DATA_W-1] != opb[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != acc_q[DATA_W-1]);
      end
      OP_AND: alu_res = acc_q & opb;
      OP_OR:  alu_res = acc_q | opb;
      OP_XOR: alu_res = acc_q ^ opb;
      OP_SLL: alu_res = acc_q << shamt;
      OP_SRA: alu_res = $signed(acc_q) >>> shamt;
      OP_MUL: alu_res = '0;
    endcase
  end

  assign mul_start = WrAcc && !mul_busy && (SelA == SELA_ALU) && (Op == OP_MUL);

  seq_multiplier #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (acc_q),
    .b       (opb),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // A completing MUL owns the write port; otherwise requests are ignored while busy.
  always_comb begin
    wr_en  = 1'b0;
    wr_val = '0;
    wr_c   = 1'b0;
    wr_v   = 1'b0;
    if (mul_done) begin
      wr_en  = 1'b1;
      wr_val = mul_product[DATA_W-1:0];
      wr_c   = |mul_product[2*DATA_W-1:DATA_W];
    end else if (WrAcc && !mul_busy) begin
      unique case (SelA)
        SELA_MEM: begin
          wr_en  = 1'b1;
          wr_val = data_from_memory;
        end
        SELA_IMM: begin
          wr_en  = 1'b1;
          wr_val = imm_sext;
        end
        SELA_ALU: begin
          wr_en  = (Op != OP_MUL);
          wr_val = alu_res;
          wr_c   = alu_c;
          wr_v   = alu_v;
        end
        SELA_HOLD: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= mul_done;
      if (wr_en) begin
        acc_q   <= wr_val;
        flags_q <= '{z: ~|wr_val, n: wr_val[DATA_W-1], c: wr_c, v: wr_v};
      end
    end
  end

  assign out_accumulator = acc_q;
  assign flag_z          = flags_q.z;
  assign flag_n          = flags_q.n;
  assign flag_c          = flags_q.c;
  assign flag_v          = flags_q.v;
  assign busy            = mul_busy;
  assign done            = done_q;

endmodule

// File: tb/tb_acc_datapath_p.sv
// Self-checking bench for acc_datapath_p: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_acc_datapath_p;

  localparam int DW = 16;
  localparam int IW = 11;

  logic            clk;
  logic            reset;
  logic [IW-1:0]   imm_operand;
  logic [DW-1:0]   data_from_memory;
  logic [1:0]      SelA;
  logic            SelB;
  logic            WrAcc;
  logic [2:0]      Op;
  logic [DW-1:0]   out_accumulator;
  logic            flag_z, flag_n, flag_c, flag_v;
  logic            busy, done;

  int passed = 0;
  int total  = 0;

  logic [15:0] m_acc;
  logic [3:0]  m_flags;

  typedef struct {
    logic        wr;
    logic [1:0]  sa;
    logic        sb;
    logic [2:0]  op;
    logic [10:0] imm;
    logic [15:0] mem;
    logic [15:0] acc;
    logic [3:0]  f;
  } vec_t;

  acc_datapath_p #(.DATA_W(DW), .IMM_W(IW)) dut (
    .clk              (clk),
    .reset            (reset),
    .imm_operand      (imm_operand),
    .data_from_memory (data_from_memory),
    .SelA             (SelA),
    .SelB             (SelB),
    .WrAcc            (WrAcc),
    .Op               (Op),
    .out_accumulator  (out_accumulator),
    .flag_z           (flag_z),
    .flag_n           (flag_n),
    .flag_c           (flag_c),
    .flag_v           (flag_v),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [21:0] snap();
    return {out_accumulator, flag_z, flag_n, flag_c, flag_v, busy, done};
  endfunction

  function automatic logic [21:0] pk(input logic [15:0] a, input logic [3:0] f,
                                     input logic b, input logic d);
    return {a, f, b, d};
  endfunction

  function automatic logic [15:0] sext(input logic [10:0] imm);
    int v;
    v = int'($signed(imm));
    return v[15:0];
  endfunction

  // Reference: result and flags from plain integer arithmetic.
  task automatic model_write(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                             input logic [10:0] imm, input logic [15:0] mem);
    logic [15:0] b, r;
    logic        c, v;
    longint      ua, ub, full;
    int          sa_i, sb_i, sr;
    b  = sb ? sext(imm) : mem;
    c  = 1'b0;
    v  = 1'b0;
    r  = m_acc;
    ua = longint'(m_acc);
    ub = longint'(b);
    sa_i = int'($signed(m_acc));
    sb_i = int'($signed(b));
    if (sa == 2'd3) return;
    if (sa == 2'd0) r = mem;
    else if (sa == 2'd1) r = sext(imm);
    else begin
      case (op)
        3'd0: begin
          full = ua + ub; r = full[15:0]; c = (full > 65535);
          sr = sa_i + sb_i; v = (sr > 32767) || (sr < -32768);
        end
        3'd1: begin
          full = ua - ub; r = full[15:0]; c = (ua >= ub);
          sr = sa_i - sb_i; v = (sr > 32767) || (sr < -32768);
        end
        3'd2: r = m_acc & b;
        3'd3: r = m_acc | b;
        3'd4: r = m_acc ^ b;
        3'd5: r = m_acc << b[3:0];
        3'd6: begin sr = sa_i >>> b[3:0]; r = sr[15:0]; end
        default: begin
          full = ua * ub; r = full[15:0]; c = (full > 65535);
        end
      endcase
    end
    m_acc   = r;
    m_flags = {r == 16'h0, r[15], c, v};
  endtask

  task automatic step(input logic wr, input logic [1:0] sa, input logic sb,
                      input logic [2:0] op, input logic [10:0] imm, input logic [15:0] mem);
    WrAcc = wr; SelA = sa; SelB = sb; Op = op;
    imm_operand = imm; data_from_memory = mem;
    @(posedge clk); #1;
    WrAcc = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; WrAcc = 1'b0; SelA = 2'd3; SelB = 1'b0; Op = 3'd0;
    imm_operand = '0; data_from_memory = '0;
    #12;
    total++;
    if (snap() !== pk(16'h0, 4'b0000, 1'b0, 1'b0))
      $display("FAIL reset_state: got %h expected %h", snap(), pk(16'h0, 4'b0000, 1'b0, 1'b0));
    else passed++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_alu();
    vec_t v[14];
    v[0]  = '{1'b1, 2'd1, 1'b1, 3'd0, 11'd5,     16'h0000, 16'h0005, 4'b0000};
    v[1]  = '{1'b1, 2'd2, 1'b1, 3'd0, 11'd4,     16'h0000, 16'h0009, 4'b0000};
    v[2]  = '{1'b1, 2'd1, 1'b1, 3'd0, 11'h7FF,   16'h0000, 16'hFFFF, 4'b0100};
    v[3]  = '{1'b1, 2'd2, 1'b1, 3'd0, 11'd1,     16'h0000, 16'h0000, 4'b1010};
    v[4]  = '{1'b1, 2'd0, 1'b0, 3'd0, 11'd0,     16'h7FFF, 16'h7FFF, 4'b0000};
    v[5]  = '{1'b1, 2'd2, 1'b1, 3'd0, 11'd1,     16'h0000, 16'h8000, 4'b0101};
    v[6]  = '{1'b1, 2'd2, 1'b0, 3'd1, 11'd0,     16'h8001, 16'hFFFF, 4'b0100};
    v[7]  = '{1'b1, 2'd3, 1'b1, 3'd0, 11'd3,     16'h1234, 16'hFFFF, 4'b0100};
    v[8]  = '{1'b0, 2'd1, 1'b1, 3'd0, 11'd0,     16'h0000, 16'hFFFF, 4'b0100};
    v[9]  = '{1'b1, 2'd2, 1'b1, 3'd1, 11'd1,     16'h0000, 16'hFFFE, 4'b0110};
    v[10] = '{1'b1, 2'd2, 1'b1, 3'd2, 11'h0F0,   16'h0000, 16'h00F0, 4'b0000};
    v[11] = '{1'b1, 2'd2, 1'b0, 3'd4, 11'd0,     16'h00F0, 16'h0000, 4'b1000};
    v[12] = '{1'b1, 2'd2, 1'b1, 3'd3, 11'h7FF,   16'h0000, 16'hFFFF, 4'b0100};
    v[13] = '{1'b1, 2'd2, 1'b1, 3'd1, 11'h7FF,   16'h0000, 16'h0000, 4'b1010};
    for (int i = 0; i < 14; i++) begin
      step(v[i].wr, v[i].sa, v[i].sb, v[i].op, v[i].imm, v[i].mem);
      total++;
      if (snap() !== pk(v[i].acc, v[i].f, 1'b0, 1'b0))
        $display("FAIL load_alu[%0d]: got %h expected %h", i, snap(), pk(v[i].acc, v[i].f, 1'b0, 1'b0));
      else passed++;
    end
  endtask

  task automatic test_mul_handshake();
    logic [21:0] exp_s;
    step(1'b1, 2'd1, 1'b1, 3'd0, 11'd9, 16'h0);
    WrAcc = 1'b1; SelA = 2'd2; SelB = 1'b1; Op = 3'd7; imm_operand = 11'd7;
    @(posedge clk); #1;
    WrAcc = 1'b0;
    total++;
    if (snap() !== pk(16'd9, 4'b0000, 1'b1, 1'b0))
      $display("FAIL mul_launch: got %h expected %h", snap(), pk(16'd9, 4'b0000, 1'b1, 1'b0));
    else passed++;
    for (int i = 1; i <= 16; i++) begin
      WrAcc = 1'b0;
      if (i == 5) begin
        WrAcc = 1'b1; SelA = 2'd1; imm_operand = 11'h055;
      end else if (i == 16) begin
        WrAcc = 1'b1; SelA = 2'd2; SelB = 1'b1; Op = 3'd7; imm_operand = 11'd7;
      end
      @(posedge clk); #1;
      WrAcc = 1'b0;
      exp_s = (i < 16) ? pk(16'd9, 4'b0000, 1'b1, 1'b0) : pk(16'd63, 4'b0000, 1'b0, 1'b1);
      total++;
      if (snap() !== exp_s)
        $display("FAIL mul_run[%0d]: got %h expected %h", i, snap(), exp_s);
      else passed++;
    end
    @(posedge clk); #1;
    total++;
    if (snap() !== pk(16'd63, 4'b0000, 1'b0, 1'b0))
      $display("FAIL mul_after_done: got %h expected %h", snap(), pk(16'd63, 4'b0000, 1'b0, 1'b0));
    else passed++;
  endtask

  task automatic test_mul_overflow_shifts();
    int cycles;
    bit ok;
    vec_t v[4];
    step(1'b1, 2'd0, 1'b0, 3'd0, 11'd0, 16'h0100);
    step(1'b1, 2'd2, 1'b0, 3'd7, 11'd0, 16'h0100);
    wait_done(cycles, ok);
    total++;
    if (!ok || cycles != 16)
      $display("FAIL mul_latency: got %0d cycles (done seen %0d) expected 16", cycles, ok);
    else passed++;
    total++;
    if (snap() !== pk(16'h0000, 4'b1010, 1'b0, 1'b1))
      $display("FAIL mul_overflow: got %h expected %h", snap(), pk(16'h0000, 4'b1010, 1'b0, 1'b1));
    else passed++;
    v[0] = '{1'b1, 2'd0, 1'b0, 3'd0, 11'd0, 16'h8000, 16'h8000, 4'b0100};
    v[1] = '{1'b1, 2'd2, 1'b1, 3'd6, 11'd4, 16'h0000, 16'hF800, 4'b0100};
    v[2] = '{1'b1, 2'd0, 1'b0, 3'd0, 11'd0, 16'h4001, 16'h4001, 4'b0000};
    v[3] = '{1'b1, 2'd2, 1'b1, 3'd5, 11'd1, 16'h0000, 16'h8002, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      step(v[i].wr, v[i].sa, v[i].sb, v[i].op, v[i].imm, v[i].mem);
      total++;
      if (snap() !== pk(v[i].acc, v[i].f, 1'b0, 1'b0))
        $display("FAIL shift[%0d]: got %h expected %h", i, snap(), pk(v[i].acc, v[i].f, 1'b0, 1'b0));
      else passed++;
    end
  endtask

  task automatic test_reset_mid_mul();
    int cycles;
    int done_seen;
    bit ok;
    step(1'b1, 2'd1, 1'b1, 3'd0, 11'd9, 16'h0);
    step(1'b1, 2'd2, 1'b1, 3'd7, 11'd7, 16'h0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (snap() !== pk(16'h0, 4'b0000, 1'b0, 1'b0))
      $display("FAIL reset_abort: got %h expected %h", snap(), pk(16'h0, 4'b0000, 1'b0, 1'b0));
    else passed++;
    @(negedge clk); @(negedge clk); reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy || out_accumulator != 16'h0) done_seen++;
    end
    total++;
    if (done_seen != 0)
      $display("FAIL reset_no_result: got %0d active cycles expected 0", done_seen);
    else passed++;
    step(1'b1, 2'd1, 1'b1, 3'd0, 11'd3, 16'h0);
    step(1'b1, 2'd2, 1'b1, 3'd7, 11'd3, 16'h0);
    wait_done(cycles, ok);
    total++;
    if (!ok || cycles != 16 || snap() !== pk(16'd9, 4'b0000, 1'b0, 1'b1))
      $display("FAIL mul_after_reset: got %h after %0d cycles expected %h after 16",
               snap(), cycles, pk(16'd9, 4'b0000, 1'b0, 1'b1));
    else passed++;
  endtask

  task automatic test_random();
    logic        wr, sb;
    logic [1:0]  sa;
    logic [2:0]  op;
    logic [10:0] imm;
    logic [15:0] mem;
    int          cycles;
    bit          ok;
    m_acc   = out_accumulator;
    m_flags = {flag_z, flag_n, flag_c, flag_v};
    for (int i = 0; i < 60; i++) begin
      wr  = ($urandom_range(0, 7) != 0);
      sa  = 2'($urandom_range(0, 3));
      sb  = 1'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 7));
      imm = 11'($urandom);
      mem = 16'($urandom);
      step(wr, sa, sb, op, imm, mem);
      if (wr) model_write(sa, sb, op, imm, mem);
      if (wr && sa == 2'd2 && op == 3'd7) begin
        wait_done(cycles, ok);
        total++;
        if (!ok || cycles != 16 || snap() !== pk(m_acc, m_flags, 1'b0, 1'b1))
          $display("FAIL rand_mul[%0d]: got %h after %0d cycles expected %h after 16",
                   i, snap(), cycles, pk(m_acc, m_flags, 1'b0, 1'b1));
        else passed++;
      end else begin
        total++;
        if (snap() !== pk(m_acc, m_flags, 1'b0, 1'b0))
          $display("FAIL rand_op[%0d] sa=%0d sb=%0d op=%0d: got %h expected %h",
                   i, sa, sb, op, snap(), pk(m_acc, m_flags, 1'b0, 1'b0));
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_alu();
    test_mul_handshake();
    test_mul_overflow_shifts();
    test_reset_mid_mul();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
